// File: rtl/hb_io_pkg.sv
// Shared constants for the HB I/O port block: I/O space nibble and register offsets.
package hb_io_pkg;

  localparam logic [3:0] IO_SPACE   = 4'hF;
  localparam logic [3:0] OFS_OUT0   = 4'd0;
  localparam logic [3:0] OFS_IN0    = 4'd4;
  localparam logic [3:0] OFS_STATUS = 4'd8;
  localparam logic [3:0] OFS_ERROR  = 4'd9;

  // True when ofs addresses channel idx of a bank starting at base.
  function automatic logic ofs_hit(input logic [3:0] ofs, input logic [3:0] base, input int idx);
    return ofs == (base + 4'(idx));
  endfunction

endpackage

// File: rtl/hb_io_in_chan.sv
// One input channel: holding register with full flag and sticky overrun flag.
module hb_io_in_chan #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              strobe,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              overrun
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dout    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A strobe coinciding with a read refills the register, so full stays set.
      if (strobe) begin
        dout <= din;
        full <= 1'b1;
      end else if (rd) begin
        full <= 1'b0;
      end
      // A new overrun wins over clear-on-read in the same cycle.
      if (strobe && full && !rd)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/hb_io_ports.sv
// Memory-mapped I/O port block: output channels with valid/ack handshake,
// input channels with holding registers, STATUS/ERROR registers and irq.
module hb_io_ports
  import hb_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 2,
  parameter int N_IN   = 1,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       io_address,
  input  logic                    csram_b,
  input  logic                    weram_b,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rdata_oe_b,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ack,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_strobe,
  output logic                    irq
);

  logic       sel;
  logic       rd;
  logic       wr;
  logic       err_clr;
  logic [3:0] ofs;

  assign sel     = en & ~csram_b & (io_address[ADDR_W-1 -: 4] == IO_SPACE);
  assign ofs     = io_address[3:0];
  assign rd      = sel & weram_b;
  assign wr      = sel & ~weram_b;
  assign err_clr = rd & (ofs == OFS_ERROR);

  if (ADDR_W > 8) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^io_address[ADDR_W-5:4];
  end

  logic [DATA_W-1:0] out_reg [N_OUT];
  logic [N_OUT-1:0]  out_valid_q;
  logic [N_OUT-1:0]  out_ovf;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
      out_valid_q <= '0;
      out_ovf     <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wr && ofs_hit(ofs, OFS_OUT0, k)) begin
          // An ack in the same cycle frees the slot before the new word lands.
          if (!out_valid_q[k] || out_ack[k]) begin
            out_reg[k]     <= wdata;
            out_valid_q[k] <= 1'b1;
          end else begin
            out_ovf[k] <= 1'b1;
          end
        end else begin
          if (out_ack[k]) out_valid_q[k] <= 1'b0;
          if (err_clr)    out_ovf[k]     <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_data[k*DATA_W +: DATA_W] = out_reg[k];
  end
  assign out_valid = out_valid_q;

  logic [DATA_W-1:0] in_reg [N_IN];
  logic [N_IN-1:0]   in_full;
  logic [N_IN-1:0]   in_ovr;

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    hb_io_in_chan #(.DATA_W(DATA_W)) u_chan (
      .clk     (clk),
      .rst_b   (rst_b),
      .strobe  (in_strobe[j]),
      .din     (in_data[j*DATA_W +: DATA_W]),
      .rd      (rd & ofs_hit(ofs, OFS_IN0, j)),
      .err_clr (err_clr),
      .dout    (in_reg[j]),
      .full    (in_full[j]),
      .overrun (in_ovr[j])
    );
  end

  logic [3:0]        valid4, full4, ovf4, ovr4;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    valid4 = '0;
    full4  = '0;
    ovf4   = '0;
    ovr4   = '0;
    valid4[N_OUT-1:0] = out_valid_q;
    ovf4[N_OUT-1:0]   = out_ovf;
    full4[N_IN-1:0]   = in_full;
    ovr4[N_IN-1:0]    = in_ovr;
    rd_word = '0;
    for (int k = 0; k < N_OUT; k++)
      if (ofs_hit(ofs, OFS_OUT0, k)) rd_word = out_reg[k];
    for (int j = 0; j < N_IN; j++)
      if (ofs_hit(ofs, OFS_IN0, j)) rd_word = in_reg[j];
    if (ofs == OFS_STATUS) rd_word = DATA_W'({full4, valid4});
    if (ofs == OFS_ERROR)  rd_word = DATA_W'({ovr4, ovf4});
  end

  assign rdata      = rd ? rd_word : '0;
  assign rdata_oe_b = ~rd;
  assign irq        = (|in_full) | (|out_ovf) | (|in_ovr);

endmodule

// File: tb/tb_hb_io_ports.sv
// Self-checking bench for hb_io_ports: directed vector table, reset corner
// sequence and randomized traffic against a behavioural register model.
module tb_hb_io_ports;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 2;
  localparam int N_IN   = 1;
  localparam int ADDR_W = 12;

  logic                    clk = 1'b0;
  logic                    rst_b;
  logic                    en;
  logic [ADDR_W-1:0]       io_address;
  logic                    csram_b;
  logic                    weram_b;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       rdata;
  logic                    rdata_oe_b;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ack;
  logic [N_IN*DATA_W-1:0]  in_data;
  logic [N_IN-1:0]         in_strobe;
  logic                    irq;

  hb_io_ports #(.DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .en         (en),
    .io_address (io_address),
    .csram_b    (csram_b),
    .weram_b    (weram_b),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_oe_b (rdata_oe_b),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the register map
  logic [7:0] m_out   [N_OUT];
  bit         m_valid [N_OUT];
  bit         m_ovf   [N_OUT];
  logic [7:0] m_in    [N_IN];
  bit         m_full  [N_IN];
  bit         m_ovr   [N_IN];

  typedef struct {
    logic        en;
    logic        cs_b;
    logic [11:0] addr;
    logic        wr;
    logic [7:0]  wd;
    logic [1:0]  ack;
    logic        stb;
    logic [7:0]  din;
    logic [7:0]  exp_rd;
    logic        exp_oe_b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) begin m_out[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; end
    for (int j = 0; j < N_IN; j++)  begin m_in[j] = 0;  m_full[j] = 0;  m_ovr[j] = 0;  end
  endtask

  function automatic bit model_irq();
    bit r = 0;
    for (int k = 0; k < N_OUT; k++) r |= m_ovf[k];
    for (int j = 0; j < N_IN; j++)  r |= m_full[j] | m_ovr[j];
    return r;
  endfunction

  task automatic idle_inputs();
    en = 1'b1; csram_b = 1'b1; io_address = '0; weram_b = 1'b1;
    wdata = '0; out_ack = '0; in_strobe = '0; in_data = '0;
  endtask

  // One bus cycle: drive, check combinational read, clock, update model, check state.
  task automatic step(input logic e, input logic cs, input logic [11:0] a, input logic w,
                      input logic [7:0] wd, input logic [1:0] ak, input logic sb,
                      input logic [7:0] di, output logic [7:0] ard, output logic aoe);
    bit sel, rd, wrt, clr;
    int ofs, s;
    logic [7:0] erd;
    en = e; csram_b = cs; io_address = a; weram_b = ~w; wdata = wd;
    out_ack = ak; in_strobe = sb; in_data = di;
    #1;
    ard = rdata; aoe = rdata_oe_b;
    sel = e && !cs && (a[11:8] == 4'hF);
    ofs = int'(a[3:0]);
    rd  = sel && !w;
    wrt = sel && w;
    erd = 0;
    if (rd) begin
      if (ofs < N_OUT) erd = m_out[ofs];
      else if (ofs >= 4 && ofs < 4 + N_IN) erd = m_in[ofs-4];
      else if (ofs == 8 || ofs == 9) begin
        s = 0;
        for (int k = 0; k < N_OUT; k++) s += (ofs == 8 ? int'(m_valid[k]) : int'(m_ovf[k])) * (2 ** k);
        for (int j = 0; j < N_IN; j++)  s += (ofs == 8 ? int'(m_full[j]) : int'(m_ovr[j])) * (2 ** (4 + j));
        erd = 8'(s);
      end
    end
    chk("rdata", 32'(ard), 32'(erd));
    chk("rdata_oe_b", 32'(aoe), 32'(!rd));
    @(posedge clk);
    clr = rd && ofs == 9;
    for (int k = 0; k < N_OUT; k++) begin
      if (clr) m_ovf[k] = 0;
      if (wrt && ofs == k) begin
        if (!m_valid[k] || ak[k]) begin m_out[k] = wd; m_valid[k] = 1; end
        else m_ovf[k] = 1;
      end else if (ak[k]) m_valid[k] = 0;
    end
    for (int j = 0; j < N_IN; j++) begin
      if (clr) m_ovr[j] = 0;
      if (sb) begin
        if (m_full[j] && !(rd && ofs == 4 + j)) m_ovr[j] = 1;
        m_in[j] = di; m_full[j] = 1;
      end else if (rd && ofs == 4 + j) m_full[j] = 0;
    end
    #1;
    for (int k = 0; k < N_OUT; k++) begin
      chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(m_out[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid[k]));
    end
    chk("irq", 32'(irq), 32'(model_irq()));
  endtask

  task automatic add(input logic e, input logic cs, input logic [11:0] a, input logic w,
                     input logic [7:0] wd, input logic [1:0] ak, input logic sb,
                     input logic [7:0] di, input logic [7:0] xr, input logic xo);
    vec_t v;
    v.en = e; v.cs_b = cs; v.addr = a; v.wr = w; v.wd = wd; v.ack = ak;
    v.stb = sb; v.din = di; v.exp_rd = xr; v.exp_oe_b = xo;
    vecs.push_back(v);
  endtask

  logic [7:0] ard;
  logic       aoe;

  initial begin
    //   en cs  addr    wr wdata ack  stb din    exp_rd oe_b
    add(1, 0, 12'hF00, 1, 8'h5A, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF00, 0, 8'h00, 2'b00, 0, 8'h00, 8'h5A, 0);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h01, 0);
    add(1, 1, 12'hF00, 0, 8'h00, 2'b01, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(1, 0, 12'hF01, 1, 8'h11, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF01, 1, 8'h22, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF01, 0, 8'h00, 2'b00, 0, 8'h00, 8'h11, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h02, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h02, 0);
    add(1, 1, 12'h000, 0, 8'h00, 2'b10, 0, 8'h00, 8'h00, 1);
    add(1, 1, 12'h000, 0, 8'h00, 2'b00, 1, 8'h3C, 8'h00, 1);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h10, 0);
    add(1, 0, 12'hF04, 0, 8'h00, 2'b00, 0, 8'h00, 8'h3C, 0);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(1, 1, 12'h000, 0, 8'h00, 2'b00, 1, 8'hAA, 8'h00, 1);
    add(1, 1, 12'h000, 0, 8'h00, 2'b00, 1, 8'hBB, 8'h00, 1);
    add(1, 0, 12'hF04, 0, 8'h00, 2'b00, 0, 8'h00, 8'hBB, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h10, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(1, 1, 12'h000, 0, 8'h00, 2'b00, 1, 8'h55, 8'h00, 1);
    add(1, 0, 12'hF04, 0, 8'h00, 2'b00, 1, 8'h77, 8'h55, 0);
    add(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, 8'h10, 0);
    add(1, 0, 12'hF04, 0, 8'h00, 2'b00, 0, 8'h00, 8'h77, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(0, 0, 12'hF00, 1, 8'h99, 2'b00, 0, 8'h00, 8'h00, 1);
    add(0, 0, 12'hF00, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hE00, 1, 8'h99, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hE00, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF00, 0, 8'h00, 2'b00, 0, 8'h00, 8'h5A, 0);
    add(1, 0, 12'hF0A, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);
    add(1, 0, 12'hF00, 1, 8'h66, 2'b00, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF00, 1, 8'h67, 2'b01, 0, 8'h00, 8'h00, 1);
    add(1, 0, 12'hF00, 0, 8'h00, 2'b00, 0, 8'h00, 8'h67, 0);
    add(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0);

    idle_inputs();
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].cs_b, vecs[i].addr, vecs[i].wr, vecs[i].wd,
           vecs[i].ack, vecs[i].stb, vecs[i].din, ard, aoe);
      chk($sformatf("vec%0d rdata", i), 32'(ard), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d oe_b", i), 32'(aoe), 32'(vecs[i].exp_oe_b));
    end

    // Held write: first cycle loads, second cycle of the same access overflows.
    step(1, 0, 12'hF01, 1, 8'hC1, 2'b00, 0, 8'h00, ard, aoe);
    step(1, 0, 12'hF01, 1, 8'hC2, 2'b00, 0, 8'h00, ard, aoe);
    chk("held write data", 32'(out_data[15:8]), 32'hC1);
    chk("held write irq", 32'(irq), 32'h1);
    step(1, 0, 12'hF09, 0, 8'h00, 2'b00, 0, 8'h00, ard, aoe);
    chk("held write error", 32'(ard), 32'h02);

    // Asynchronous reset in the middle of a pending handshake.
    step(1, 1, 12'h000, 0, 8'h00, 2'b00, 1, 8'h12, ard, aoe);
    idle_inputs();
    #2;
    rst_b = 1'b0;
    #1;
    model_reset();
    chk("async rst out_valid", 32'(out_valid), 32'h0);
    chk("async rst out_data", 32'(out_data), 32'h0);
    chk("async rst irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("post rst out_valid", 32'(out_valid), 32'h0);
    step(1, 0, 12'hF08, 0, 8'h00, 2'b00, 0, 8'h00, ard, aoe);
    chk("post rst status", 32'(ard), 32'h00);

    for (int i = 0; i < 400; i++) begin
      logic        e, cs, w, sb;
      logic [11:0] a;
      logic [1:0]  ak;
      e  = ($urandom % 8) != 0;
      cs = ($urandom % 4) == 0;
      if ($urandom % 8 == 0) a = {4'($urandom % 15), 8'($urandom)};
      else                   a = {4'hF, 4'($urandom), 4'($urandom % 12)};
      w  = 1'($urandom % 2);
      ak = {2'($urandom % 3) == 0, 2'($urandom % 3) == 0};
      sb = ($urandom % 3) == 0;
      step(e, cs, a, w, 8'($urandom), ak, sb, 8'($urandom), ard, aoe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hb_io_ports.md
HB_IO_PORTS -- requirements
Module: hb_io_ports

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the I/O data width (8..16).
REQ-002 SHALL have parameter N_OUT, default 2, meaning the number of output channels (1..4).
REQ-003 SHALL have parameter N_IN, default 1, meaning the number of input channels (1..4).
REQ-004 SHALL have parameter ADDR_W, default 12, meaning the io_address width (>=8).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit: device enable (bootloader done); when 0, no bus access takes effect.
REQ-008 SHALL have port io_address, input, ADDR_W bits: CPU I/O address.
REQ-009 SHALL have port csram_b, input, 1 bit: active-low bus cycle select.
REQ-010 SHALL have port weram_b, input, 1 bit: active-low write; 1 means read.
REQ-011 SHALL have port wdata, input, DATA_W bits: CPU write data.
REQ-012 SHALL have port rdata, output, DATA_W bits: CPU read data.
REQ-013 SHALL have port rdata_oe_b, output, 1 bit: active-low databus drive enable.
REQ-014 SHALL have port out_data, output, N_OUT*DATA_W bits: output channel data, channel k in slice k.
REQ-015 SHALL have port out_valid, output, N_OUT bits: output data pending, per channel.
REQ-016 SHALL have port out_ack, input, N_OUT bits: consumer accepted the pending data, per channel.
REQ-017 SHALL have port in_data, input, N_IN*DATA_W bits: input channel data.
REQ-018 SHALL have port in_strobe, input, N_IN bits: producer presents in_data, one-cycle pulse per word.
REQ-019 SHALL have port irq, output, 1 bit: OR of all in_full bits and all error bits.

Function
REQ-020 SHALL decode sel = en & ~csram_b & (io_address[ADDR_W-1:ADDR_W-4] == 4'hF), with offset = io_address[3:0].
REQ-021 SHALL map offsets 0..N_OUT-1 to output data, 4..4+N_IN-1 to input data, 8 to STATUS, 9 to ERROR; all other offsets read 0 and ignore writes.
REQ-022 SHALL drive rdata_oe_b = 0 combinationally only while sel & weram_b; rdata SHALL be 0 otherwise.
REQ-023 SHALL define STATUS as bits[3:0] = out_valid and bits[7:4] = in_full, with unimplemented channel bits reading 0.
REQ-024 SHALL define ERROR as bits[3:0] = out_overflow and bits[7:4] = in_overrun, all sticky.
REQ-025 SHALL, on a write to output offset k, load out_data[k] and set out_valid[k] at the same edge when out_valid[k] = 0.
REQ-026 SHALL, on a write to output k while out_valid[k] = 1 and out_ack[k] = 0, keep the old data and set out_overflow[k].
REQ-027 SHALL treat out_ack[k] and a write in the same cycle as acceptance followed by load, giving new data, valid = 1 and no overflow.
REQ-028 SHALL clear out_valid[k] on out_ack[k] with no write; out_ack while not valid SHALL be ignored.
REQ-029 SHALL return the last written out_data[k] when output offset k is read.
REQ-030 SHALL, on in_strobe[j], latch in_data[j] into the holding register and set in_full[j].
REQ-031 SHALL, on in_strobe[j] while in_full[j] = 1 with no read of channel j, overwrite the data and set in_overrun[j].
REQ-032 SHALL, on a read of input offset 4+j, return the held data and clear in_full[j] at the end of that cycle.
REQ-033 SHALL, on a read of channel j and in_strobe[j] in the same cycle, return the old data, latch the new data, keep in_full = 1 and not flag an overrun.
REQ-034 SHALL clear-on-read the ERROR register; an error event in the same cycle as the read SHALL remain set.
REQ-035 SHALL take effect for a bus access held for several cycles on every cycle of the access (the CPU holds csram_b for one cycle).

Reset
REQ-036 SHALL, while rst_b = 0, force out_data, out_valid, in holding registers, in_full, all error bits and irq to 0, independent of clk.
REQ-037 SHALL treat reset during a pending handshake as aborting it; out_valid SHALL read 0 on the first edge after release.

Structure
REQ-038 SHALL take register offsets (OFS_OUT0 = 0, OFS_IN0 = 4, OFS_STATUS = 8, OFS_ERROR = 9) and the I/O space nibble 4'hF from shared package hb_io_pkg.
REQ-039 SHALL implement each input channel as one instance of sub-module hb_io_in_chan (holding register, full flag, overrun flag), generated N_IN times.

Verification
REQ-040 Write 0x5A to offset 0 -> out_data[0] = 0x5A and out_valid[0] = 1 at the next edge; out_ack[0] pulse -> out_valid[0] = 0.
REQ-041 Write 0x11 then 0x22 to offset 1 with no ack -> out_data[1] = 0x11, ERROR reads 0x02, then ERROR reads 0x00.
REQ-042 in_strobe[0] with 0x3C, then read offset 4 -> rdata = 0x3C, rdata_oe_b = 0, STATUS afterwards = 0x00.
REQ-043 Two strobes (0xAA, 0xBB) with no read -> offset 4 reads 0xBB, ERROR = 0x10, irq = 1 until both are cleared.
REQ-044 Read offset 4 in the same cycle as a strobe of 0x77 -> old data is returned, in_full stays 1, next read returns 0x77, ERROR = 0.
REQ-045 en = 0, or an address outside 0xF00-0xFFF, with a write -> no state change and rdata_oe_b = 1; rst_b low mid-handshake -> all outputs 0 asynchronously.
